ddr3_traffic_gen: RTL and testbench

- Write-then-read-back traffic initiator on the MIG 7-series user (app_*) interface, the command-issuing side facing the DDR3 controller inside top.
- Writes NUM_BURSTS bursts of a seeded pattern to sequential addresses, reads them back in order, compares the returned data, and reports pass/fail, error count and timeout.
- Used for bring-up in simulation against the DDR3 memory model and on hardware after init_calib_complete.

---
 rtl/ddr3_traffic_gen.sv | 202 ++++++++++++++++++++
 tb/tb_ddr3_traffic_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_traffic_gen.sv
// Write-then-read-back traffic initiator for the MIG 7-series app_* interface.
// Writes NUM_BURSTS seeded bursts, reads them back in order and reports the result.
module ddr3_traffic_gen #(
  parameter int                    ADDR_WIDTH = 29,
  parameter int                    DATA_WIDTH = 512,
  parameter int                    NUM_BURSTS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           SEED       = 32'hA5A5_0000,
  parameter int                    TIMEOUT    = 65535
) (
  input  logic                      ui_clk,
  input  logic                      rst_n,
  input  logic                      init_calib_complete,
  input  logic                      start,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [DATA_WIDTH-1:0]     app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
  input  logic                      app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]     app_rd_data,
  input  logic                      app_rd_data_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               err_count,
  output logic [2:0]                state_dbg
);

  localparam int CW    = $clog2(NUM_BURSTS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int WORDS = DATA_WIDTH / 32;
  localparam logic [CW-1:0] CNT_ALL  = CW'(NUM_BURSTS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BURSTS - 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cc;        // commands accepted in the current phase
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [CW-1:0]           wd;
  logic [31:0]             wword;
  logic [CW-1:0]           rc;
  logic [31:0]             rword;
  logic [TW-1:0]           idle_cnt;
  logic                    cmp_pend;
  logic                    cmp_bad;

  logic cmd_hs, wdf_hs, rd_hs, any_hs;
  logic run, start_ok, abort;
  logic wcmd_fin, wdat_fin;

  assign state_dbg    = state;
  assign app_wdf_mask = '0;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay constant until that edge.
  assign cmd_hs   = app_en & app_rdy;
  assign wdf_hs   = app_wdf_wren & app_wdf_rdy;
  assign rd_hs    = app_rd_data_valid && (state == S_READ || state == S_DRAIN) && (rc != CNT_ALL);
  assign any_hs   = cmd_hs | wdf_hs | rd_hs;
  assign run      = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign start_ok = start && init_calib_complete && (state == S_IDLE || state == S_DONE);
  // Calibration loss is folded into the timeout path.
  assign abort    = run && (!init_calib_complete || (!any_hs && idle_cnt == IDLE_MAX));
  assign wcmd_fin = (cc == CNT_ALL) || (cmd_hs && cc == CNT_LAST);
  assign wdat_fin = (wd == CNT_ALL) || (wdf_hs && wd == CNT_LAST);

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_wdf_data = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (cc != CNT_ALL) begin
          app_en   = 1'b1;
          app_addr = cmd_addr;
        end
        if (wd != CNT_ALL) begin
          app_wdf_wren = 1'b1;
          app_wdf_end  = 1'b1;
          app_wdf_data = {WORDS{wword}};
        end
        if (abort)                     state_nxt = S_DONE;
        else if (wcmd_fin && wdat_fin) state_nxt = S_READ;
      end
      S_READ: begin
        app_en   = 1'b1;
        app_cmd  = 3'b001;
        app_addr = cmd_addr;
        if (abort)                         state_nxt = S_DONE;
        else if (cmd_hs && cc == CNT_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)               state_nxt = S_DONE;
        else if (rc == CNT_ALL)  state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      cc       <= '0;
      cmd_addr <= '0;
      wd       <= '0;
      wword    <= '0;
      rc       <= '0;
      rword    <= '0;
      cmp_pend <= 1'b0;
      cmp_bad  <= 1'b0;
    end else begin
      cmp_pend <= rd_hs;
      cmp_bad  <= (app_rd_data != {WORDS{rword}});
      if (start_ok) begin
        cc       <= '0;
        cmd_addr <= BASE_ADDR;
        wd       <= '0;
        wword    <= SEED;
        rc       <= '0;
        rword    <= SEED;
      end else begin
        // The read phase replays the same address sequence from the base.
        if (state == S_WRITE && state_nxt == S_READ) begin
          cc       <= '0;
          cmd_addr <= BASE_ADDR;
        end else if (cmd_hs) begin
          cc       <= cc + CW'(1);
          cmd_addr <= cmd_addr + ADDR_WIDTH'(8);
        end
        if (wdf_hs) begin
          wd    <= wd + CW'(1);
          wword <= wword + 32'd1;
        end
        if (rd_hs) begin
          rc    <= rc + CW'(1);
          rword <= rword + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!run || any_hs) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
    end else if (start_ok) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
    end else begin
      if (abort) timeout <= 1'b1;
      if (cmp_pend && cmp_bad && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      // Status is published one edge after entering DONE so the last compare has landed.
      if (state == S_DONE && !done) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (err_count == 16'd0) && !timeout;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Directed bench for ddr3_traffic_gen: a behavioural MIG responder with memory,
// and a linear sequence of directed steps checked with immediate assertions.
module tb_ddr3_traffic_gen;

  localparam int AW  = 29;
  localparam int DW  = 512;
  localparam int NB  = 4;
  localparam int TO  = 100;
  localparam int LAT = 3;
  localparam logic [31:0]  SEED   = 32'hA5A5_0000;
  localparam logic [AW-1:0] WBASE = 29'h1FFF_FFF8;

  // clock / reset
  logic ui_clk = 1'b0;
  logic rst_n;
  logic init_calib_complete;
  always #5 ui_clk = ~ui_clk;

  logic            start;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en, app_rdy;
  logic [DW-1:0]   app_wdf_data;
  logic            app_wdf_wren, app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic            app_wdf_rdy;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_valid;
  logic            busy, done, pass, timeout;
  logic [15:0]     err_count;
  logic [2:0]      state_dbg;

  logic            start_w;
  logic [AW-1:0]   app_addr_w;
  logic [2:0]      app_cmd_w;
  logic            app_en_w;
  logic            app_rdy_w = 1'b1;
  logic [DW-1:0]   app_wdf_data_w;
  logic            app_wdf_wren_w, app_wdf_end_w;
  logic [DW/8-1:0] app_wdf_mask_w;
  logic            app_wdf_rdy_w = 1'b1;
  logic [DW-1:0]   app_rd_data_w = '0;
  logic            app_rd_data_valid_w = 1'b0;
  logic            busy_w, done_w, pass_w, timeout_w;
  logic [15:0]     err_count_w;
  logic [2:0]      state_dbg_w;

  ddr3_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BURSTS(NB),
    .BASE_ADDR('0), .SEED(SEED), .TIMEOUT(TO)
  ) dut (
    .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .start(start), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  // Second instance placed just below the top of the address space.
  ddr3_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BURSTS(2),
    .BASE_ADDR(WBASE), .SEED(SEED), .TIMEOUT(TO)
  ) dut_w (
    .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .start(start_w), .app_addr(app_addr_w), .app_cmd(app_cmd_w), .app_en(app_en_w),
    .app_rdy(app_rdy_w), .app_wdf_data(app_wdf_data_w), .app_wdf_wren(app_wdf_wren_w),
    .app_wdf_end(app_wdf_end_w), .app_wdf_mask(app_wdf_mask_w), .app_wdf_rdy(app_wdf_rdy_w),
    .app_rd_data(app_rd_data_w), .app_rd_data_valid(app_rd_data_valid_w),
    .busy(busy_w), .done(done_w), .pass(pass_w), .timeout(timeout_w),
    .err_count(err_count_w), .state_dbg(state_dbg_w)
  );

  // scoreboard state
  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  // responder state
  int            cyc = 0;
  int            rdy_mode = 0;
  bit            chk_stable = 1'b0;
  int            flip_burst = -1;
  int            n_wcmd, n_wdat, n_rdret;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [DW-1:0] mem[int];
  logic [AW-1:0] wr_log[$];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] rp_addr[$];
  int            rp_due[$];
  logic [DW-1:0] rd_tmp;
  bit            prev_cmd_wait, prev_wdf_wait;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] w);
    pat = {16{w}};
  endfunction

  task automatic clear_logs();
    n_wcmd = 0; n_wdat = 0; n_rdret = 0;
    wa_q.delete(); wd_q.delete(); mem.delete();
    wr_log.delete(); rd_log.delete(); rp_addr.delete(); rp_due.delete();
    prev_cmd_wait = 1'b0; prev_wdf_wait = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge ui_clk) start = 1'b1;
    @(negedge ui_clk) start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int nbusy);
    int n;
    n = 0;
    nbusy = 0;
    while (!done && n < limit) begin
      if (busy) nbusy++;
      @(negedge ui_clk);
      n++;
    end
    chk("done_within_bound", done, 1'b1);
  endtask

  task automatic check_run(input string tag);
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(pat(SEED + 32'(i)));
      exp_addr_q.push_back(AW'(8 * i));
    end
    chk({tag, "_wr_count"}, wr_log.size(), NB);
    chk({tag, "_rd_count"}, rd_log.size(), NB);
    for (int i = 0; i < NB; i++) begin
      if (i < wr_log.size()) chk($sformatf("%s_wr_addr%0d", tag, i), wr_log[i], exp_addr_q[i]);
      if (i < rd_log.size()) chk($sformatf("%s_rd_addr%0d", tag, i), rd_log[i], exp_addr_q[i]);
      chk($sformatf("%s_mem%0d", tag, i), mem.exists(i) ? mem[i] : '0, exp_q[i]);
    end
  endtask

  // MIG responder: decides ready/read data at each falling edge for the next rising edge.
  initial begin
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
    forever begin
      @(negedge ui_clk);
      cyc++;
      if (chk_stable && prev_cmd_wait) begin
        chk("cmd_valid_held", app_en, 1'b1);
        chk("addr_stable", app_addr, prev_addr);
      end
      if (chk_stable && prev_wdf_wait) begin
        chk("wdf_valid_held", app_wdf_wren, 1'b1);
        chk("wdata_stable", app_wdf_data, prev_data);
      end
      if (rp_due.size() > 0 && rp_due[0] <= cyc) begin
        rd_tmp = mem.exists(int'(rp_addr[0] >> 3)) ? mem[int'(rp_addr[0] >> 3)] : '0;
        if (n_rdret == flip_burst) rd_tmp[0] = ~rd_tmp[0];
        app_rd_data = rd_tmp;
        app_rd_data_valid = 1'b1;
        n_rdret++;
        void'(rp_addr.pop_front());
        void'(rp_due.pop_front());
      end else begin
        app_rd_data = '0;
        app_rd_data_valid = 1'b0;
      end
      case (rdy_mode)
        0: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
        1: begin
          app_wdf_rdy = 1'($urandom_range(0, 1));
          app_rdy = (app_cmd == 3'b001 || n_wdat >= n_wcmd + 3 || n_wdat >= NB)
                    ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        2: begin app_wdf_rdy = 1'b1; app_rdy = (app_cmd != 3'b001); end
        default: begin app_rdy = 1'b0; app_wdf_rdy = 1'b0; end
      endcase
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) begin
          wa_q.push_back(app_addr);
          wr_log.push_back(app_addr);
          n_wcmd++;
        end else begin
          rd_log.push_back(app_addr);
          rp_addr.push_back(app_addr);
          rp_due.push_back(cyc + LAT);
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        wd_q.push_back(app_wdf_data);
        n_wdat++;
      end
      while (wa_q.size() > 0 && wd_q.size() > 0) begin
        mem[int'(wa_q[0] >> 3)] = wd_q[0];
        void'(wa_q.pop_front());
        void'(wd_q.pop_front());
      end
      prev_cmd_wait = app_en && !app_rdy;
      prev_wdf_wait = app_wdf_wren && !app_wdf_rdy;
      prev_addr = app_addr;
      prev_data = app_wdf_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int n;
    rst_n = 1'b0; start = 1'b0; start_w = 1'b0; init_calib_complete = 1'b0;
    clear_logs();
    repeat (3) @(negedge ui_clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_err", err_count, 16'd0);
    chk("rst_state", state_dbg, 3'd0);
    rst_n = 1'b1;
    @(negedge ui_clk);

    // start without calibration is ignored
    pulse_start();
    chk("nocal_busy", busy, 1'b0);
    chk("nocal_en", app_en, 1'b0);
    init_calib_complete = 1'b1;

    // address wrap on the second instance
    @(negedge ui_clk) start_w = 1'b1;
    @(negedge ui_clk) start_w = 1'b0;
    chk("wrap_addr0", app_addr_w, WBASE);
    @(negedge ui_clk);
    chk("wrap_en1", app_en_w, 1'b1);
    chk("wrap_addr1", app_addr_w, '0);

    // ideal controller
    clear_logs();
    rdy_mode = 0;
    pulse_start();
    chk("t1_busy_first", busy, 1'b1);
    chk("t1_en_first", app_en, 1'b1);
    chk("t1_wren_first", app_wdf_wren, 1'b1);
    chk("t1_addr_first", app_addr, '0);
    chk("t1_data_first", app_wdf_data, pat(SEED));
    wait_done(500, nb);
    chk("t1_busy_cycles", nb, 4 + 4 + LAT + 2);
    chk("t1_pass", pass, 1'b1);
    chk("t1_err", err_count, 16'd0);
    chk("t1_timeout", timeout, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    check_run("t1");

    // random readiness, data leading commands by 3
    clear_logs();
    rdy_mode = 1;
    chk_stable = 1'b1;
    pulse_start();
    wait_done(2000, nb);
    chk_stable = 1'b0;
    chk("t2_pass", pass, 1'b1);
    chk("t2_err", err_count, 16'd0);
    chk("t2_timeout", timeout, 1'b0);
    check_run("t2");

    // corrupted read of burst 2
    clear_logs();
    rdy_mode = 0;
    flip_burst = 2;
    pulse_start();
    wait_done(500, nb);
    flip_burst = -1;
    chk("t3_err", err_count, 16'd1);
    chk("t3_pass", pass, 1'b0);
    chk("t3_done", done, 1'b1);
    chk("t3_timeout", timeout, 1'b0);

    // read commands stalled until timeout
    clear_logs();
    rdy_mode = 2;
    pulse_start();
    n = 0;
    while (state_dbg != 3'd2 && n < 50) begin
      @(negedge ui_clk);
      n++;
    end
    chk("t4_reach_read", state_dbg, 3'd2);
    n = 0;
    while (!done && n < 300) begin
      @(negedge ui_clk);
      n++;
      if (n == TO) begin
        chk("t4_timeout_fire", timeout, 1'b1);
        chk("t4_en_dropped", app_en, 1'b0);
        chk("t4_done_not_yet", done, 1'b0);
        chk("t4_state_done", state_dbg, 3'd4);
      end
    end
    chk("t4_done_cycle", n, TO + 1);
    chk("t4_timeout", timeout, 1'b1);
    chk("t4_pass", pass, 1'b0);
    chk("t4_busy", busy, 1'b0);

    // calibration loss mid-write
    clear_logs();
    rdy_mode = 3;
    pulse_start();
    @(negedge ui_clk);
    chk("t5_in_write", state_dbg, 3'd1);
    init_calib_complete = 1'b0;
    @(negedge ui_clk);
    chk("t5_timeout", timeout, 1'b1);
    chk("t5_state", state_dbg, 3'd4);
    chk("t5_en", app_en, 1'b0);
    chk("t5_wren", app_wdf_wren, 1'b0);
    @(negedge ui_clk);
    chk("t5_done", done, 1'b1);
    chk("t5_pass", pass, 1'b0);
    init_calib_complete = 1'b1;

    // asynchronous reset mid-write, then a clean rerun
    clear_logs();
    rdy_mode = 1;
    pulse_start();
    @(negedge ui_clk);
    chk("t6_en_before", app_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en", app_en, 1'b0);
    chk("t6_wren", app_wdf_wren, 1'b0);
    chk("t6_wdf_end", app_wdf_end, 1'b0);
    chk("t6_addr", app_addr, '0);
    chk("t6_cmd", app_cmd, 3'd0);
    chk("t6_wdata", app_wdf_data, '0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_state", state_dbg, 3'd0);
    @(negedge ui_clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    clear_logs();
    @(negedge ui_clk);
    pulse_start();
    wait_done(500, nb);
    chk("t6_pass", pass, 1'b1);
    chk("t6_err", err_count, 16'd0);
    check_run("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
